bcd_digit_seq: RTL and testbench
================================

Name: bcd_digit_seq

Overview:
- Serial controller that applies the team's 4-bit digit code map to a packed multi-digit BCD word, one digit per clock, through a single shared map instance.
- Accepts a word on a valid/ready input handshake and sequences the digits through the map, least significant digit first.
- Returns the assembled word on a valid/ready output handshake.
- Sits between a BCD word producer (keypad/register file) and a display/ALU consumer.

Parameters:
NDIG, 4, number of BCD digits per word (≥1); word width W = 4*NDIG

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  producer offers in_data
in_ready  out  1  block can accept a word
in_data  in  W  packed BCD word, digit k = in_data[4k+3:4k]
out_valid  out  1  out_data/err valid
out_ready  in  1  consumer accepts result
out_data  out  W  mapped word, digit k = map(digit k of accepted word)
err  out  1  at least one input digit was >9
busy  out  1  high in RUN state

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n). The state machine, digit index, data register, out_data and err are all asynchronously cleared by rst_n.
- Digit map (combinational, 4-bit to 4-bit), inputs 0..9 map to:
  - 0→0, 1→7, 2→6, 3→5, 4→4
  - 5→B, 6→A, 7→9, 8→8, 9→F
- Invalid digits (A..F):
  - The mapped digit is forced to F.
  - The word's sticky err flag is set.
- State machine:
  - IDLE:
    - in_ready=1.
    - in_valid&in_ready at an edge: latch in_data, idx←0, err←0, go to RUN.
  - RUN:
    - Each edge writes map(digit idx) into out_data digit idx and ORs the invalid flag into err; idx←idx+1.
    - On the edge processing idx=NDIG-1, go to DONE.
  - DONE:
    - out_valid=1; out_data and err are held stable.
    - out_valid&out_ready at an edge: go to IDLE.
- Latency: out_valid rises exactly NDIG edges after the accepting edge.
- Throughput: one word per NDIG+2 cycles minimum. in_ready is low in RUN and DONE; there is no overlap.
- Output decode: in_ready, out_valid and busy are decoded from the state only. There is no combinational path from in_valid to in_ready or from out_ready to out_valid.
- Reset values:
  - in_ready=1, out_valid=0, busy=0, out_data=0, err=0.
  - State IDLE, idx=0.
- Boundaries:
  - out_ready held low in DONE: the block stalls indefinitely with outputs stable.
  - out_ready high before DONE: ignored.
  - in_valid while not IDLE: ignored; the producer must hold its data.
  - rst_n asserted mid-RUN or mid-DONE: the word is discarded and all outputs return to reset values immediately.
  - idx width is clog2(NDIG), minimum 1. idx never exceeds NDIG-1.
  - out_data is cleared to 0 on entry to RUN.

Optional Feature:
- Macro BCD_DIGIT_SEQ_ERRIDX_EN.
- Defined:
  - Adds output err_idx [clog2(NDIG)-1:0], the index of the lowest invalid digit in the current word.
  - err_idx is valid with out_valid and is 0 when err=0.
  - It is cleared on accept and on reset, and captured only on the first invalid digit.
- Undefined: no err_idx port and no capture logic; all other behaviour is identical.

Decomposition:
- Package bcd_seq_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - DIGIT_W=4, DIGIT_MAX=9, DIGIT_INVALID=4'hF
- Sub-module bcd_digit_map: purely combinational.
  - digit[3:0] → code[3:0], invalid.
  - It is instantiated once and muxed by idx.

Test Plan:
- Reset, then in_data=16'h1234 accepted at edge k → out_valid at edge k+4 with out_data=16'h7654, err=0; in_ready=0 until the output handshake completes.
- in_data=16'h9508 → out_data=16'hFB08, err=0.
- in_data=16'h12A4 → out_data=16'h76F4, err=1; with ERRIDX_EN, err_idx=1.
- Backpressure: out_ready=0 for 3 cycles in DONE → out_valid=1 and out_data/err stable; in_ready=0; the next word is accepted only after the handshake.
- rst_n pulsed low during RUN (after 2 digits of 16'h5678) → out_valid=0, out_data=0, busy=0, in_ready=1; a subsequent 16'h0000 gives out_data=16'h0000, err=0.
- Exhaustive: all 16 digit values at each position with NDIG=4 and NDIG=1 → matches the map table; err set exactly for inputs A..F.

Source files
------------

// File: rtl/bcd_seq_pkg.sv
// rtl/bcd_seq_pkg.sv - shared states and digit constants for the BCD digit sequencer
package bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int                   DIGIT_W       = 4;
  localparam logic [DIGIT_W-1:0]   DIGIT_MAX     = 4'd9;
  localparam logic [DIGIT_W-1:0]   DIGIT_INVALID = 4'hF;

endpackage

// File: rtl/bcd_digit_map.sv
// rtl/bcd_digit_map.sv - combinational 4-bit digit code map with invalid-digit flag
module bcd_digit_map
  import bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] code,
  output logic               invalid
);

  always_comb begin
    invalid = (digit > DIGIT_MAX);
    case (digit)
      4'd0:    code = 4'h0;
      4'd1:    code = 4'h7;
      4'd2:    code = 4'h6;
      4'd3:    code = 4'h5;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'hB;
      4'd6:    code = 4'hA;
      4'd7:    code = 4'h9;
      4'd8:    code = 4'h8;
      4'd9:    code = 4'hF;
      default: code = DIGIT_INVALID;
    endcase
  end

endmodule

// File: rtl/bcd_digit_seq.sv
// rtl/bcd_digit_seq.sv - serial BCD word mapper, one digit per clock; BCD_DIGIT_SEQ_ERRIDX_EN adds err_idx
module bcd_digit_seq
  import bcd_seq_pkg::*;
#(
  parameter  int NDIG  = 4,
  localparam int W     = 4 * NDIG,
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             err,
`ifdef BCD_DIGIT_SEQ_ERRIDX_EN
  output logic [IDX_W-1:0] err_idx,
`endif
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [W-1:0]         data_q;
  logic [DIGIT_W-1:0]   cur_digit;
  logic [DIGIT_W-1:0]   cur_code;
  logic                 cur_invalid;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);

  // Single shared map: select the digit under idx from the latched word.
  always_comb begin
    cur_digit = data_q[DIGIT_W-1:0];
    for (int k = 0; k < NDIG; k++) begin
      if (idx == IDX_W'(k)) cur_digit = data_q[4*k +: 4];
    end
  end

  bcd_digit_map u_map (
    .digit   (cur_digit),
    .code    (cur_code),
    .invalid (cur_invalid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      data_q   <= '0;
      out_data <= '0;
      err      <= 1'b0;
`ifdef BCD_DIGIT_SEQ_ERRIDX_EN
      err_idx  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            idx      <= '0;
            err      <= 1'b0;
            out_data <= '0;
`ifdef BCD_DIGIT_SEQ_ERRIDX_EN
            err_idx  <= '0;
`endif
            state    <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < NDIG; k++) begin
            if (idx == IDX_W'(k)) out_data[4*k +: 4] <= cur_code;
          end
          err <= err | cur_invalid;
`ifdef BCD_DIGIT_SEQ_ERRIDX_EN
          // err is still clear only until the first invalid digit lands
          if (cur_invalid && !err) err_idx <= idx;
`endif
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_digit_seq.sv
// tb/tb_bcd_digit_seq.sv - bench for bcd_digit_seq (NDIG=4 and NDIG=1), honours BCD_DIGIT_SEQ_ERRIDX_EN
module tb_bcd_digit_seq;

  localparam logic [3:0] TBL [16] = '{4'h0, 4'h7, 4'h6, 4'h5, 4'h4, 4'hB, 4'hA, 4'h9,
                                      4'h8, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_err, a_busy;
  logic [15:0] a_in_data = '0, a_out_data;
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_err, b_busy;
  logic [3:0]  b_in_data = '0, b_out_data;
`ifdef BCD_DIGIT_SEQ_ERRIDX_EN
  logic [1:0]  a_err_idx;
  logic        b_err_idx;
`endif

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  bcd_digit_seq #(.NDIG(4)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .err       (a_err),
`ifdef BCD_DIGIT_SEQ_ERRIDX_EN
    .err_idx   (a_err_idx),
`endif
    .busy      (a_busy)
  );

  bcd_digit_seq #(.NDIG(1)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .err       (b_err),
`ifdef BCD_DIGIT_SEQ_ERRIDX_EN
    .err_idx   (b_err_idx),
`endif
    .busy      (b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: digit k of w is (w / 16^k) mod 16, each looked up in the code table.
  function automatic logic [15:0] ref_data(input logic [15:0] w);
    logic [15:0] r = '0;
    for (int k = 0; k < 4; k++) begin
      int dv = (int'(w) >> (4 * k)) % 16;
      r = r | (16'(TBL[dv]) << (4 * k));
    end
    return r;
  endfunction

  function automatic int ref_err_idx(input logic [15:0] w);
    for (int k = 0; k < 4; k++) begin
      if (((int'(w) >> (4 * k)) % 16) > 9) return k;
    end
    return -1;
  endfunction

  task automatic run4(input logic [15:0] w, input int stall);
    int cnt = 0;
    int ei = ref_err_idx(w);
    logic [15:0] exp_d = ref_data(w);
    chk("a_idle_in_ready", 32'(a_in_ready), 1);
    a_out_ready = (stall == 0);
    a_in_valid  = 1'b1;
    a_in_data   = w;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_in_data  = ~w;
    chk("a_run_in_ready", 32'(a_in_ready), 0);
    chk("a_run_busy", 32'(a_busy), 1);
    while (!a_out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("a_latency", 32'(cnt), 4);
    chk("a_out_data", 32'(a_out_data), 32'(exp_d));
    chk("a_err", 32'(a_err), 32'(ei >= 0));
`ifdef BCD_DIGIT_SEQ_ERRIDX_EN
    chk("a_err_idx", 32'(a_err_idx), (ei >= 0) ? 32'(ei) : 0);
`endif
    for (int i = 0; i < stall; i++) begin
      a_in_valid = 1'b1;
      @(posedge clk); #1;
      chk("a_stall_valid", 32'(a_out_valid), 1);
      chk("a_stall_data", 32'(a_out_data), 32'(exp_d));
      chk("a_stall_err", 32'(a_err), 32'(ei >= 0));
      chk("a_stall_in_ready", 32'(a_in_ready), 0);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    chk("a_post_out_valid", 32'(a_out_valid), 0);
    chk("a_post_in_ready", 32'(a_in_ready), 1);
  endtask

  task automatic run1(input logic [3:0] d);
    int cnt = 0;
    chk("b_idle_in_ready", 32'(b_in_ready), 1);
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_data   = d;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    chk("b_run_busy", 32'(b_busy), 1);
    while (!b_out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("b_latency", 32'(cnt), 1);
    chk("b_out_data", 32'(b_out_data), 32'(TBL[int'(d)]));
    chk("b_err", 32'(b_err), 32'(int'(d) > 9));
`ifdef BCD_DIGIT_SEQ_ERRIDX_EN
    chk("b_err_idx", 32'(b_err_idx), 0);
`endif
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    chk("b_post_out_valid", 32'(b_out_valid), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(a_in_ready), 1);
    chk("rst_out_valid", 32'(a_out_valid), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_out_data", 32'(a_out_data), 0);
    chk("rst_err", 32'(a_err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run4(16'h1234, 0);
    run4(16'h9508, 0);
    run4(16'h12A4, 0);
    run4(16'h1234, 3);

    // Reset mid-RUN after two digits of 16'h5678
    a_in_valid = 1'b1;
    a_in_data  = 16'h5678;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_partial_data", 32'(a_out_data), 32'h0098);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(a_out_valid), 0);
    chk("mid_rst_out_data", 32'(a_out_data), 0);
    chk("mid_rst_busy", 32'(a_busy), 0);
    chk("mid_rst_in_ready", 32'(a_in_ready), 1);
    chk("mid_rst_err", 32'(a_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run4(16'h0000, 0);

    for (int v = 0; v < 16; v++) begin
      run4({4{4'(v)}}, 0);
      run1(4'(v));
    end

    for (int i = 0; i < 24; i++) begin
      run4(16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
